// File: rtl/nibble_add_seq_112.sv
// nibble_add_seq_112: 16-bit add/subtract sequenced over four cycles through an
// external 4-bit CLA adder slice, least-significant nibble first.
// Optional feature macro: NIBADD_SUB_EN. When it is defined, sub=1 selects a-b.
// When it is undefined, the sub port is kept but ignored, and the block always adds.
module nibble_add_seq_112 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sub,
    input  logic [16:1] a,
    input  logic [16:1] b,
    output logic [4:1]  nib_x,
    output logic [4:1]  nib_y,
    output logic        nib_c0,
    input  logic [4:1]  nib_f,
    input  logic        nib_c4,
    output logic [16:1] sum,
    output logic        cout,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [16:1] a_reg_q, a_reg_d;
    logic [16:1] b_reg_q, b_reg_d;
    logic        carry_q, carry_d;
    logic [1:0]  idx_q,   idx_d;
    logic [16:1] sum_q,   sum_d;
    logic        cout_q,  cout_d;
    logic        ovf_q,   ovf_d;

    logic [16:1] a_sh;
    logic [16:1] b_sh;

`ifndef NIBADD_SUB_EN
    // The sub port stays on the interface but has no function in an add-only build.
    logic sub_unused;
    assign sub_unused = sub;
`endif

    // Select the active nibble of each operand; the slice sees zeros outside RUN.
    always_comb begin
        a_sh   = a_reg_q >> {idx_q, 2'b00};
        b_sh   = b_reg_q >> {idx_q, 2'b00};
        nib_x  = 4'h0;
        nib_y  = 4'h0;
        nib_c0 = 1'b0;
        if (state_q == S_RUN) begin
            nib_x  = a_sh[4:1];
            nib_y  = b_sh[4:1];
            nib_c0 = carry_q;
        end
    end

    // Next-state logic: accept an operation, step through four nibbles, pulse done.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_reg_d = a;
`ifdef NIBADD_SUB_EN
                    // Subtraction is a + ~b + 1; the +1 enters as the first carry-in.
                    b_reg_d = sub ? ~b : b;
                    carry_d = sub;
`else
                    b_reg_d = b;
                    carry_d = 1'b0;
`endif
                    idx_d   = 2'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                case (idx_q)
                    2'd0:    sum_d[4:1]   = nib_f;
                    2'd1:    sum_d[8:5]   = nib_f;
                    2'd2:    sum_d[12:9]  = nib_f;
                    default: sum_d[16:13] = nib_f;
                endcase
                carry_d = nib_c4;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cout_d  = nib_c4;
                    // Signed overflow: both operands have the same sign, but the result sign differs.
                    ovf_d   = (a_reg_q[16] == b_reg_q[16]) && (nib_f[4] != a_reg_q[16]);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_reg_q <= '0;
            b_reg_q <= '0;
            carry_q <= 1'b0;
            idx_q   <= 2'd0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all flops update together from pre-edge values.
            state_q <= state_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_nibble_add_seq_112.sv
// Self-checking bench for nibble_add_seq_112 with a behavioural 4-bit adder slice.
// Expected values depend on NIBADD_SUB_EN in the same way as the design build.
module tb_nibble_add_seq_112;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [16:1] a;
    logic [16:1] b;
    logic [4:1]  nib_x;
    logic [4:1]  nib_y;
    logic        nib_c0;
    logic [4:1]  nib_f;
    logic        nib_c4;
    logic [16:1] sum;
    logic        cout;
    logic        ovf;
    logic        busy;
    logic        done;

    int total;
    int bad;

    nibble_add_seq_112 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .nib_x  (nib_x),
        .nib_y  (nib_y),
        .nib_c0 (nib_c0),
        .nib_f  (nib_f),
        .nib_c4 (nib_c4),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    // External adder slice model.
    assign {nib_c4, nib_f} = {1'b0, nib_x} + {1'b0, nib_y} + {4'b0000, nib_c0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
        logic [3:0]  exp_c0;   // nib_c0 seen in RUN cycles 0..3 (bit 0 = first cycle)
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one operation. Then sample on falling edges until done is seen, within a bounded budget.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          output int lat, output int busy_cnt, output logic [3:0] c0_seq,
                          output logic timed_out);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cnt = 0; c0_seq = 4'h0; timed_out = 1'b0;
        while (!done && lat < 20) begin
            if (busy) begin
                if (busy_cnt < 4) c0_seq[busy_cnt] = nib_c0;
                busy_cnt++;
            end
            @(negedge clk);
            lat++;
        end
        if (!done) timed_out = 1'b1;
    endtask

    initial begin
        int          lat;
        int          bcnt;
        logic [3:0]  c0s;
        logic        tmo;
        int          dcnt;

        total = 0;
        bad   = 0;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'b0000};
`ifdef NIBADD_SUB_EN
        vecs[5] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001};
        vecs[6] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 4'b1111};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0001};
`else
        vecs[5] = '{16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, 1'b0, 4'b0000};
        vecs[6] = '{16'h0007, 16'h0005, 1'b1, 16'h000C, 1'b0, 1'b0, 4'b0000};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b0, 4'b0000};
`endif

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_sum",  {16'h0, sum}, 32'h0);
        check("reset_flags", {27'h0, cout, ovf, busy, done, nib_c0}, 32'h0);
        check("reset_nib",  {24'h0, nib_x, nib_y}, 32'h0);
        rst_n = 1'b1;

        // Table-driven operations.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, lat, bcnt, c0s, tmo);
            check($sformatf("v%0d_timeout", i), {31'h0, tmo}, 32'h0);
            check($sformatf("v%0d_latency", i), lat, 5);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 4);
            check($sformatf("v%0d_c0_seq", i), {28'h0, c0s}, {28'h0, vecs[i].exp_c0});
            check($sformatf("v%0d_sum", i), {16'h0, sum}, {16'h0, vecs[i].exp_sum});
            check($sformatf("v%0d_cout", i), {31'h0, cout}, {31'h0, vecs[i].exp_cout});
            check($sformatf("v%0d_ovf", i), {31'h0, ovf}, {31'h0, vecs[i].exp_ovf});
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {30'h0, done, busy}, 32'h0);
        end

        // Idle hold: outputs keep the last result, and the slice inputs stay at zero.
        a = 16'hDEAD; b = 16'hBEEF; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_hold_sum", {16'h0, sum}, {16'h0, vecs[7].exp_sum});
        check("idle_hold_flags", {30'h0, cout, ovf}, {30'h0, vecs[7].exp_cout, vecs[7].exp_ovf});
        check("idle_nib_zero", {23'h0, nib_x, nib_y, nib_c0}, 32'h0);

        // A start re-pulsed with new operands during RUN must be ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                dcnt++;
                check("restart_sum", {16'h0, sum}, 32'h2345);
                check("restart_flags", {30'h0, cout, ovf}, 32'h0);
            end
            @(negedge clk);
        end
        check("restart_done_count", dcnt, 1);

        // Reset during the second RUN cycle aborts the operation, with no done pulse.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_in_run", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_sum_async", {16'h0, sum}, 32'h0);
        check("abort_flags_async", {27'h0, cout, ovf, busy, done, nib_c0}, 32'h0);
        check("abort_nib_async", {24'h0, nib_x, nib_y}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        check("abort_no_done", dcnt, 0);
        run_op(16'h0001, 16'h0001, 1'b0, lat, bcnt, c0s, tmo);
        check("post_reset_timeout", {31'h0, tmo}, 32'h0);
        check("post_reset_latency", lat, 5);
        check("post_reset_sum", {16'h0, sum}, 32'h0002);
        check("post_reset_flags", {30'h0, cout, ovf}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
